// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared pipeline widths, PC index and the MEM/WB bundle type
package wb_stage_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_REG_ADDR_W = 4;
  localparam int WB_CNT_W = 32;
  localparam int WB_PC_REG = 15;
  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic [WB_REG_ADDR_W-1:0] dest;
    logic [WB_DATA_W-1:0] alu_res;
    logic [WB_DATA_W-1:0] mem_data;
  } wb_bundle_t;
endpackage

// File: rtl/wb_stage_reg.sv
// wb_stage_reg: freezable, flushable MEM/WB register with a valid bit
module wb_stage_reg
  import wb_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       freeze_i,
  input  logic       flush_i,
  input  logic       valid_i,
  input  wb_bundle_t bundle_i,
  output logic       valid_o,
  output wb_bundle_t bundle_o
);
  logic v_q, v_d;
  wb_bundle_t b_q, b_d;
  // next state: flush kills the entry even when frozen; freeze holds everything else
  always_comb begin
    v_d = v_q;
    b_d = b_q;
    if (flush_i) begin
      v_d = 1'b0;
      b_d.wb_en = 1'b0;
    end else if (!freeze_i) begin
      v_d = valid_i;
      b_d = bundle_i;
      b_d.wb_en = bundle_i.wb_en & valid_i;
    end
  end
  // stage register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      b_q <= '0;
    end else begin
      v_q <= v_d;
      b_q <= b_d;
    end
  end
  assign valid_o = v_q;
  assign bundle_o = b_q;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, result select, PC write guard, retire counter
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_ADDR_W = WB_REG_ADDR_W,
  parameter int CNT_W = WB_CNT_W,
  parameter int PC_REG = WB_PC_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  MEM_WB_EN,
  input  logic                  MEM_R_EN,
  input  logic [DATA_W-1:0]     ALU_Res,
  input  logic [DATA_W-1:0]     Mem_Data,
  input  logic [REG_ADDR_W-1:0] Dest,
  output logic                  WB_EN,
  output logic [REG_ADDR_W-1:0] WB_Dest,
  output logic [DATA_W-1:0]     WB_Value,
  output logic [CNT_W-1:0]      retired,
  output logic                  pc_wr_err
);
  wb_bundle_t b_in, b_q;
  logic v_q, pc_hit;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic err_q, err_d;
  assign b_in = '{wb_en: MEM_WB_EN, mem_r_en: MEM_R_EN, dest: Dest,
                  alu_res: ALU_Res, mem_data: Mem_Data};
  wb_stage_reg u_reg (
    .clk      (clk),
    .rst      (rst),
    .freeze_i (freeze),
    .flush_i  (flush),
    .valid_i  (valid_in),
    .bundle_i (b_in),
    .valid_o  (v_q),
    .bundle_o (b_q)
  );
  assign pc_hit = b_q.dest == REG_ADDR_W'(PC_REG);
  assign WB_Value = b_q.mem_r_en ? b_q.mem_data : b_q.alu_res;
  assign WB_Dest = b_q.dest;
  assign WB_EN = v_q & b_q.wb_en & ~pc_hit;
  // count real captures; the error flag latches any suppressed PC write
  always_comb begin
    retired_d = (valid_in & ~freeze & ~flush) ? retired_q + 1'b1 : retired_q;
    err_d = err_q | (v_q & b_q.wb_en & pc_hit);
  end
  // debug state, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      err_q <= 1'b0;
    end else begin
      retired_q <= retired_d;
      err_q <= err_d;
    end
  end
  assign retired = retired_q;
  assign pc_wr_err = err_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors with hand-computed expectations for wb_stage
module tb_wb_stage;
  logic clk = 1'b0, rst = 1'b0, freeze = 1'b0, flush = 1'b0;
  logic valid_in = 1'b0, MEM_WB_EN = 1'b0, MEM_R_EN = 1'b0;
  logic [31:0] ALU_Res = '0, Mem_Data = '0;
  logic [3:0] Dest = '0;
  logic WB_EN, pc_wr_err;
  logic [3:0] WB_Dest;
  logic [31:0] WB_Value, retired;
  logic s_valid = 1'b0;
  logic s_en, s_err;
  logic [3:0] s_dest, s_cnt;
  logic [31:0] s_value;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .MEM_WB_EN(MEM_WB_EN), .MEM_R_EN(MEM_R_EN), .ALU_Res(ALU_Res),
    .Mem_Data(Mem_Data), .Dest(Dest), .WB_EN(WB_EN), .WB_Dest(WB_Dest),
    .WB_Value(WB_Value), .retired(retired), .pc_wr_err(pc_wr_err)
  );

  wb_stage #(.CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .freeze(1'b0), .flush(1'b0), .valid_in(s_valid),
    .MEM_WB_EN(1'b1), .MEM_R_EN(1'b0), .ALU_Res(32'h1), .Mem_Data(32'h2),
    .Dest(4'd1), .WB_EN(s_en), .WB_Dest(s_dest), .WB_Value(s_value),
    .retired(s_cnt), .pc_wr_err(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic rd,
                       input logic [3:0] d, input logic [31:0] alu, input logic [31:0] mem);
    valid_in = v; MEM_WB_EN = we; MEM_R_EN = rd; Dest = d; ALU_Res = alu; Mem_Data = mem;
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b0, 4'd6, 32'h66, 32'h0);
    #3 rst = 1'b1;
    #1;
    chk("rst_en", {31'b0, WB_EN}, 32'd0);
    chk("rst_dest", {28'b0, WB_Dest}, 32'd0);
    chk("rst_value", WB_Value, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_err", {31'b0, pc_wr_err}, 32'd0);
    step();
    step();
    chk("rst_held_en", {31'b0, WB_EN}, 32'd0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'd3, 32'h0000000D, 32'hFFFFFFFF);
    step();
    chk("alu_en", {31'b0, WB_EN}, 32'd1);
    chk("alu_dest", {28'b0, WB_Dest}, 32'd3);
    chk("alu_value", WB_Value, 32'h0D);
    chk("alu_retired", retired, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 4'd7, 32'h100, 32'h7);
    step();
    chk("load_value", WB_Value, 32'h7);
    chk("load_dest", {28'b0, WB_Dest}, 32'd7);
    drive(1'b1, 1'b1, 1'b0, 4'd7, 32'h22, 32'h7);
    step();
    chk("b2b_value", WB_Value, 32'h22);
    chk("b2b_en", {31'b0, WB_EN}, 32'd1);
    chk("b2b_retired", retired, 32'd3);
    drive(1'b1, 1'b1, 1'b0, 4'd2, 32'h55, 32'h0);
    step();
    chk("frz_cap_value", WB_Value, 32'h55);
    chk("frz_cap_retired", retired, 32'd4);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd9 + 4'(i), 32'h99 + 32'(i), 32'h0);
      step();
      chk("frz_en", {31'b0, WB_EN}, 32'd1);
      chk("frz_dest", {28'b0, WB_Dest}, 32'd2);
      chk("frz_value", WB_Value, 32'h55);
      chk("frz_retired", retired, 32'd4);
    end
    freeze = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'd9, 32'h99, 32'h0);
    step();
    chk("unfrz_dest", {28'b0, WB_Dest}, 32'd9);
    chk("unfrz_value", WB_Value, 32'h99);
    chk("unfrz_retired", retired, 32'd5);
    flush = 1'b1; freeze = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 4'd4, 32'h44, 32'h0);
    step();
    chk("flfrz_en", {31'b0, WB_EN}, 32'd0);
    chk("flfrz_retired", retired, 32'd5);
    flush = 1'b0; freeze = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 4'd5, 32'h5A, 32'h0);
    step();
    chk("inval_en", {31'b0, WB_EN}, 32'd0);
    chk("inval_retired", retired, 32'd5);
    drive(1'b1, 1'b1, 1'b0, 4'd15, 32'hAB, 32'h0);
    step();
    chk("pc_en", {31'b0, WB_EN}, 32'd0);
    chk("pc_dest", {28'b0, WB_Dest}, 32'd15);
    chk("pc_err_early", {31'b0, pc_wr_err}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 4'd1, 32'h11, 32'h0);
    step();
    chk("pc_err_set", {31'b0, pc_wr_err}, 32'd1);
    chk("after_pc_en", {31'b0, WB_EN}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    step();
    step();
    chk("pc_err_sticky", {31'b0, pc_wr_err}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst2_err", {31'b0, pc_wr_err}, 32'd0);
    chk("rst2_retired", retired, 32'd0);
    chk("rst2_en", {31'b0, WB_EN}, 32'd0);
    step();
    rst = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("wrap_max", {28'b0, s_cnt}, 32'hF);
    chk("wrap_en", {31'b0, s_en}, 32'd1);
    step();
    chk("wrap_zero", {28'b0, s_cnt}, 32'd0);
    s_valid = 1'b0;
    step();
    chk("wrap_hold", {28'b0, s_cnt}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
